screen_select_io: RTL and testbench

// - Parametrised PicoBlaze I/O block that picks one of NUM_SCREENS colour sources for the VGA path and drives the LEDs.
// - Latches game events (keyboard, player-win) as rising edges and raises a maskable interrupt.
// - Screen changes requested by firmware take effect only on the next frame_start pulse, so a frame never tears.
// - Sits between the PicoBlaze core, the screen generators and the VGA colour output.

---
 rtl/screen_io_pkg.sv | 9 +
 rtl/evt_irq_ctrl.sv | 33 +++
 rtl/screen_select_io.sv | 72 +++++++
 tb/tb_screen_select_io.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/screen_io_pkg.sv
// screen_io_pkg: PicoBlaze port addresses shared by the screen select I/O block
package screen_io_pkg;
  localparam logic [7:0] PORT_PEND = 8'h00;
  localparam logic [7:0] PORT_EVT  = 8'h01;
  localparam logic [7:0] PORT_LED  = 8'h02;
  localparam logic [7:0] PORT_SEL  = 8'h03;
  localparam logic [7:0] PORT_MASK = 8'h04;
  localparam logic [7:0] PORT_MODE = 8'h05;
endpackage

// File: rtl/evt_irq_ctrl.sv
// evt_irq_ctrl: rising-edge event latch with W1C pending bits and maskable interrupt
module evt_irq_ctrl #(
  parameter int NUM_EVT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               clr_we,
  input  logic [NUM_EVT-1:0] clr_bits,
  input  logic               mask_we,
  input  logic [NUM_EVT-1:0] mask_bits,
  input  logic               interrupt_ack,
  output logic [NUM_EVT-1:0] pending,
  output logic [NUM_EVT-1:0] irq_mask,
  output logic               interrupt
);
  logic [NUM_EVT-1:0] evt_q, rise;
  logic edge_hit;
  assign rise = evt & ~evt_q;
  assign edge_hit = |(rise & irq_mask);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      evt_q     <= '0;
      pending   <= '0;
      irq_mask  <= '1;
      interrupt <= 1'b0;
    end else begin
      evt_q     <= evt;
      pending   <= (clr_we ? pending & ~clr_bits : pending) | rise;
      irq_mask  <= mask_we ? mask_bits : irq_mask;
      interrupt <= edge_hit ? 1'b1 : interrupt_ack ? 1'b0 : interrupt;
    end
endmodule

// File: rtl/screen_select_io.sv
// screen_select_io: PicoBlaze I/O for frame-synchronous screen selection, LEDs and event interrupts
module screen_select_io
  import screen_io_pkg::*;
#(
  parameter int                     NUM_SCREENS = 4,
  parameter int                     COLOR_W     = 12,
  parameter int                     NUM_EVT     = 4,
  parameter int                     LED_W       = 8,
  parameter logic [NUM_SCREENS-1:0] CLEAR_MASK  = 4'b1100,
  localparam int                    SEL_W       = $clog2(NUM_SCREENS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SCREENS*COLOR_W-1:0] screens,
  input  logic                           frame_start,
  input  logic [NUM_EVT-1:0]             evt,
  input  logic [7:0]                     port_id,
  input  logic                           write_strobe,
  input  logic [7:0]                     out_port,
  output logic [7:0]                     in_port,
  output logic                           interrupt,
  input  logic                           interrupt_ack,
  output logic [COLOR_W-1:0]             color,
  output logic [SEL_W-1:0]               mode,
  output logic [LED_W-1:0]               led,
  output logic                           reset_plyrScrn
);
  logic [NUM_EVT-1:0] pending, irq_mask;
  logic [SEL_W-1:0] req_sel;
  logic [7:0] rd_data;
  logic wr_pend, wr_led, wr_sel, wr_mask;
  assign wr_pend = write_strobe && port_id == PORT_PEND;
  assign wr_led  = write_strobe && port_id == PORT_LED;
  assign wr_sel  = write_strobe && port_id == PORT_SEL && int'(out_port) < NUM_SCREENS;
  assign wr_mask = write_strobe && port_id == PORT_MASK;
  evt_irq_ctrl #(.NUM_EVT(NUM_EVT)) u_evt (
    .clk          (clk),
    .reset        (reset),
    .evt          (evt),
    .clr_we       (wr_pend),
    .clr_bits     (out_port[NUM_EVT-1:0]),
    .mask_we      (wr_mask),
    .mask_bits    (out_port[NUM_EVT-1:0]),
    .interrupt_ack(interrupt_ack),
    .pending      (pending),
    .irq_mask     (irq_mask),
    .interrupt    (interrupt)
  );
  always_comb
    rd_data = port_id == PORT_PEND ? 8'(pending)  :
              port_id == PORT_EVT  ? 8'(evt)      :
              port_id == PORT_SEL  ? 8'(req_sel)  :
              port_id == PORT_MASK ? 8'(irq_mask) :
              port_id == PORT_MODE ? 8'(mode)     : 8'h00;
  // mode samples the pre-write req_sel, so a same-cycle write waits for the next frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_port        <= '0;
      led            <= '0;
      req_sel        <= '0;
      mode           <= '0;
      color          <= '0;
      reset_plyrScrn <= CLEAR_MASK[0];
    end else begin
      in_port        <= rd_data;
      led            <= wr_led ? out_port[LED_W-1:0] : led;
      req_sel        <= wr_sel ? out_port[SEL_W-1:0] : req_sel;
      mode           <= frame_start ? req_sel : mode;
      color          <= screens[int'(mode)*COLOR_W +: COLOR_W];
      reset_plyrScrn <= CLEAR_MASK[mode];
    end
endmodule

// File: tb/tb_screen_select_io.sv
// tb_screen_select_io: directed-vector bench for screen_select_io
module tb_screen_select_io;
  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] screens;
  logic        frame_start;
  logic [3:0]  evt;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [11:0] color;
  logic [1:0]  mode;
  logic [7:0]  led;
  logic        reset_plyrScrn;
  int vectors = 0;
  int errors = 0;

  screen_select_io dut (
    .clk(clk), .reset(reset), .screens(screens), .frame_start(frame_start), .evt(evt),
    .port_id(port_id), .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .color(color), .mode(mode),
    .led(led), .reset_plyrScrn(reset_plyrScrn)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    port_id = a; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (color !== 12'h000) begin errors++; $display("FAIL reset_color got %h exp 000", color); end
    vectors++; if (reset_plyrScrn !== 1'b0) begin errors++; $display("FAIL reset_plyr got %b exp 0", reset_plyrScrn); end
    vectors++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_in_port got %h exp 00", in_port); end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (color !== 12'h111) begin errors++; $display("FAIL run_color got %h exp 111", color); end
    wr(8'h02, 8'h55);
    wr(8'h04, 8'h03);
    wr(8'h03, 8'h01);
    pulse_frame();
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL pre_reset_mode got %0d exp 1", mode); end
    wr(8'h03, 8'h03);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (color !== 12'h000) begin errors++; $display("FAIL async_color got %h exp 000", color); end
    vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL async_mode got %0d exp 0", mode); end
    vectors++; if (led !== 8'h00) begin errors++; $display("FAIL async_led got %h exp 00", led); end
    vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL async_irq got %b exp 0", interrupt); end
    vectors++; if (dut.u_evt.irq_mask !== 4'hF) begin errors++; $display("FAIL async_mask got %h exp F", dut.u_evt.irq_mask); end
    @(negedge clk); reset = 1'b0;
    pulse_frame();
    vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL req_dropped got %0d exp 0", mode); end
  endtask

  task automatic test_switch();
    wr(8'h03, 8'h02);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++; if (mode !== 2'd0) begin errors++; $display("FAIL defer_mode cyc %0d got %0d exp 0", i, mode); end
    end
    pulse_frame();
    vectors++; if (mode !== 2'd2) begin errors++; $display("FAIL switch_mode got %0d exp 2", mode); end
    vectors++; if (color !== 12'h111) begin errors++; $display("FAIL color_lag got %h exp 111", color); end
    @(negedge clk);
    vectors++; if (color !== 12'hABC) begin errors++; $display("FAIL switch_color got %h exp ABC", color); end
    vectors++; if (reset_plyrScrn !== 1'b1) begin errors++; $display("FAIL switch_plyr got %b exp 1", reset_plyrScrn); end
    wr(8'h03, 8'h07);
    pulse_frame();
    vectors++; if (mode !== 2'd2) begin errors++; $display("FAIL illegal_mode got %0d exp 2", mode); end
    port_id = 8'h03;
    @(negedge clk);
    vectors++; if (in_port !== 8'h02) begin errors++; $display("FAIL illegal_req got %h exp 02", in_port); end
    @(negedge clk);
    port_id = 8'h03; out_port = 8'h01; write_strobe = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0; frame_start = 1'b0;
    vectors++; if (mode !== 2'd2) begin errors++; $display("FAIL race_mode got %0d exp 2", mode); end
    pulse_frame();
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL race_next got %0d exp 1", mode); end
    @(negedge clk);
    vectors++; if (color !== 12'h222 || reset_plyrScrn !== 1'b0) begin errors++; $display("FAIL mode1_out got %h/%b exp 222/0", color, reset_plyrScrn); end
    wr(8'h03, 8'h02);
    pulse_frame();
  endtask

  task automatic test_edge();
    @(negedge clk); evt = 4'b0010;
    @(negedge clk);
    vectors++; if (dut.u_evt.pending !== 4'b0010) begin errors++; $display("FAIL edge_pend got %b exp 0010", dut.u_evt.pending); end
    vectors++; if (interrupt !== 1'b1) begin errors++; $display("FAIL edge_irq got %b exp 1", interrupt); end
    interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
    vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_irq got %b exp 0", interrupt); end
    repeat (3) @(negedge clk);
    vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL held_irq got %b exp 0", interrupt); end
  endtask

  task automatic test_w1c();
    @(negedge clk); evt = 4'b0000;
    @(negedge clk);
    evt = 4'b0010; port_id = 8'h00; out_port = 8'h02; write_strobe = 1'b1;
    @(negedge clk); write_strobe = 1'b0;
    vectors++; if (dut.u_evt.pending[1] !== 1'b1) begin errors++; $display("FAIL w1c_race got %b exp 1", dut.u_evt.pending[1]); end
    wr(8'h00, 8'h02);
    vectors++; if (dut.u_evt.pending !== 4'b0000) begin errors++; $display("FAIL w1c_clear got %b exp 0000", dut.u_evt.pending); end
    interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
  endtask

  task automatic test_mask();
    wr(8'h04, 8'h01);
    @(negedge clk); evt = 4'b0110;
    @(negedge clk); evt = 4'b0010;
    vectors++; if (dut.u_evt.pending[2] !== 1'b1) begin errors++; $display("FAIL mask_pend got %b exp 1", dut.u_evt.pending[2]); end
    vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mask_irq got %b exp 0", interrupt); end
    wr(8'h04, 8'h05);
    vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL unmask_irq got %b exp 0", interrupt); end
    @(negedge clk); evt = 4'b0011;
    @(negedge clk); evt = 4'b0010;
    vectors++; if (interrupt !== 1'b1) begin errors++; $display("FAIL evt0_irq got %b exp 1", interrupt); end
    @(negedge clk); evt = 4'b0011; interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
    vectors++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ack_race got %b exp 1", interrupt); end
    interrupt_ack = 1'b1;
    @(negedge clk); interrupt_ack = 1'b0;
    vectors++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_clear got %b exp 0", interrupt); end
  endtask

  task automatic test_readback();
    @(negedge clk); port_id = 8'h05;
    @(negedge clk);
    vectors++; if (in_port !== 8'h02) begin errors++; $display("FAIL rd_mode got %h exp 02", in_port); end
    port_id = 8'h07;
    @(negedge clk);
    vectors++; if (in_port !== 8'h00) begin errors++; $display("FAIL rd_unmapped got %h exp 00", in_port); end
    port_id = 8'h04;
    @(negedge clk);
    vectors++; if (in_port !== 8'h05) begin errors++; $display("FAIL rd_mask got %h exp 05", in_port); end
    port_id = 8'h01; evt = 4'b1001;
    @(negedge clk);
    vectors++; if (in_port !== 8'h09) begin errors++; $display("FAIL rd_evt got %h exp 09", in_port); end
    port_id = 8'h00;
    @(negedge clk);
    vectors++; if (in_port !== 8'h0D) begin errors++; $display("FAIL rd_pend got %h exp 0D", in_port); end
    wr(8'h02, 8'hA5);
    vectors++; if (led !== 8'hA5) begin errors++; $display("FAIL led_wr got %h exp A5", led); end
    wr(8'h06, 8'h3C);
    vectors++; if (led !== 8'hA5) begin errors++; $display("FAIL led_other got %h exp A5", led); end
  endtask

  initial begin
    reset = 1'b1; screens = {12'hDEF, 12'hABC, 12'h222, 12'h111};
    frame_start = 1'b0; evt = '0; port_id = '0; write_strobe = 1'b0; out_port = '0; interrupt_ack = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_switch();
    test_edge();
    test_w1c();
    test_mask();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
